roi_shift_harness: RTL and testbench

Serial-to-parallel/parallel-to-serial I/O harness that feeds a bitstream-fuzzing ROI (BRAM/LUT under test) from a single-pin serial input and returns its parallel result on a single-pin serial output. Sits between the top-level pins (`di`, `stb`, `sdo`) and the ROI's `din`/`dout` buses. Adds a programmable capture delay so registered ROI outputs are sampled correctly. Adds fill/drain counters and status flags so the board-side driver can pace frames.

---
 rtl/roi_harness_pkg.sv | 14 +
 rtl/roi_harness_cap_fsm.sv | 70 +++++++
 rtl/roi_shift_harness.sv | 95 +++++++++
 tb/tb_roi_shift_harness.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/roi_harness_pkg.sv
// Shared types and width helpers for the ROI serial shift harness.
package roi_harness_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/roi_harness_cap_fsm.sv
// Strobe acceptance and capture-delay sequencing for the ROI shift harness.
module roi_harness_cap_fsm
    import roi_harness_pkg::*;
#(
    parameter int CAP_DLY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    output logic load_din,
    output logic capture,
    output logic busy,
    output logic stb_drop
);

    // CAP_DLY is legal only up to 15, so four bits always suffice.
    localparam logic [3:0] DLY_INIT = (CAP_DLY > 0) ? 4'(CAP_DLY - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] dly_cnt_q, dly_cnt_d;
    logic       stb_drop_q, stb_drop_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dly_cnt_q  <= 4'd0;
            stb_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            stb_drop_q <= stb_drop_d;
        end
    end

    // A strobe arriving in WAIT, including on the capture edge, is discarded.
    always_comb begin
        state_d    = state_q;
        dly_cnt_d  = dly_cnt_q;
        stb_drop_d = 1'b0;
        load_din   = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (stb) begin
                    load_din = 1'b1;
                    if (CAP_DLY == 0) begin
                        capture = 1'b1;
                    end else begin
                        dly_cnt_d = DLY_INIT;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                stb_drop_d = stb;
                if (dly_cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    dly_cnt_d = dly_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == WAIT);
    assign stb_drop = stb_drop_q;

endmodule

// File: rtl/roi_shift_harness.sv
// Serial-in / serial-out harness around a parallel ROI: shifts frames in on di,
// drives them to the ROI, captures its result after CAP_DLY cycles and shifts it out on sdo.
module roi_shift_harness
    import roi_harness_pkg::*;
#(
    parameter int DIN_N   = 256,
    parameter int DOUT_N  = 256,
    parameter int CAP_DLY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              di,
    input  logic              stb,
    output logic              sdo,
    output logic [DIN_N-1:0]  din,
    input  logic [DOUT_N-1:0] dout,
    output logic              busy,
    output logic              in_full,
    output logic              out_valid,
    output logic              stb_drop
);

    localparam int IN_W  = cnt_w(DIN_N);
    localparam int OUT_W = cnt_w(DOUT_N);
    localparam logic [IN_W-1:0]  IN_MAX  = IN_W'(DIN_N);
    localparam logic [IN_W-1:0]  IN_ONE  = IN_W'(1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(DOUT_N);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

    logic              load_din;
    logic              capture;

    logic [DIN_N-1:0]  din_shr_q, din_shr_d;
    logic [DOUT_N-1:0] dout_shr_q, dout_shr_d;
    logic [DIN_N-1:0]  din_q, din_d;
    logic [IN_W-1:0]   in_cnt_q, in_cnt_d;
    logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;

    roi_harness_cap_fsm #(
        .CAP_DLY (CAP_DLY)
    ) u_cap_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .stb      (stb),
        .load_din (load_din),
        .capture  (capture),
        .busy     (busy),
        .stb_drop (stb_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_shr_q  <= '0;
            dout_shr_q <= '0;
            din_q      <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
        end else begin
            din_shr_q  <= din_shr_d;
            dout_shr_q <= dout_shr_d;
            din_q      <= din_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    // The accepted-strobe cycle's di already belongs to the next frame, hence in_cnt restarts at 1.
    always_comb begin
        din_shr_d  = {din_shr_q[DIN_N-2:0], di};
        dout_shr_d = capture ? dout : {dout_shr_q[DOUT_N-2:0], din_shr_q[DIN_N-1]};
        din_d      = load_din ? din_shr_q : din_q;

        if (load_din) begin
            in_cnt_d = IN_ONE;
        end else if (in_cnt_q == IN_MAX) begin
            in_cnt_d = in_cnt_q;
        end else begin
            in_cnt_d = in_cnt_q + IN_ONE;
        end

        if (capture) begin
            out_cnt_d = OUT_MAX;
        end else if (out_cnt_q == '0) begin
            out_cnt_d = out_cnt_q;
        end else begin
            out_cnt_d = out_cnt_q - OUT_ONE;
        end
    end

    assign din       = din_q;
    assign sdo       = dout_shr_q[DOUT_N-1];
    assign in_full   = (in_cnt_q == IN_MAX);
    assign out_valid = (out_cnt_q != '0);

endmodule

// File: tb/tb_roi_shift_harness.sv
// Scoreboarded bench for roi_shift_harness: one instance with CAP_DLY=0, one with CAP_DLY=3.
module tb_roi_shift_harness;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n_a, di_a, stb_a;
    logic [N-1:0] dout_a;
    logic         sdo_a, busy_a, in_full_a, out_valid_a, stb_drop_a;
    logic [N-1:0] din_a;

    logic         rst_n_b, di_b, stb_b;
    logic [N-1:0] dout_b;
    logic         sdo_b, busy_b, in_full_b, out_valid_b, stb_drop_b;
    logic [N-1:0] din_b;

    int vectors     = 0;
    int miscompares = 0;

    logic exp_a[$];
    logic exp_b[$];

    roi_shift_harness #(.DIN_N(N), .DOUT_N(N), .CAP_DLY(0)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .di(di_a), .stb(stb_a), .sdo(sdo_a),
        .din(din_a), .dout(dout_a), .busy(busy_a), .in_full(in_full_a),
        .out_valid(out_valid_a), .stb_drop(stb_drop_a)
    );

    roi_shift_harness #(.DIN_N(N), .DOUT_N(N), .CAP_DLY(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .di(di_b), .stb(stb_b), .sdo(sdo_b),
        .din(din_b), .dout(dout_b), .busy(busy_b), .in_full(in_full_b),
        .out_valid(out_valid_b), .stb_drop(stb_drop_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one cycle of di/stb into instance a (which=0) or b (which=1).
    task automatic applyStimulus(input int which, input logic d, input logic s);
        if (which == 0) begin
            di_a  = d;
            stb_a = s;
        end else begin
            di_b  = d;
            stb_b = s;
        end
        tick();
    endtask

    // Expected serial order is MSB first.
    task automatic pushByte(input int which, input logic [7:0] v);
        for (int k = 7; k >= 0; k--) begin
            if (which == 0) exp_a.push_back(v[k]);
            else            exp_b.push_back(v[k]);
        end
    endtask

    // Call from the cycle after a capture edge (offset = cycles already elapsed since it).
    task automatic drainCheck(input int which, input int offset);
        repeat (7 - offset) applyStimulus(which, 1'b0, 1'b0);
        if (which == 0) begin
            checkOutput("a_out_valid_last", 32'(out_valid_a), 32'd1);
            tick();
            checkOutput("a_out_valid_done", 32'(out_valid_a), 32'd0);
            checkOutput("a_queue_drained", 32'(exp_a.size()), 32'd0);
        end else begin
            checkOutput("b_out_valid_last", 32'(out_valid_b), 32'd1);
            tick();
            checkOutput("b_out_valid_done", 32'(out_valid_b), 32'd0);
            checkOutput("b_queue_drained", 32'(exp_b.size()), 32'd0);
        end
    endtask

    task automatic checkAllZero(input string tag, input logic [N-1:0] din_v, input logic sdo_v,
                                input logic busy_v, input logic full_v, input logic valid_v,
                                input logic drop_v);
        checkOutput({tag, "_din"}, 32'(din_v), 32'd0);
        checkOutput({tag, "_sdo"}, 32'(sdo_v), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy_v), 32'd0);
        checkOutput({tag, "_in_full"}, 32'(full_v), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(valid_v), 32'd0);
        checkOutput({tag, "_stb_drop"}, 32'(drop_v), 32'd0);
    endtask

    initial begin
        logic [7:0]  fill_pat;
        logic [7:0]  drop_pat;
        logic [19:0] lb_pat;
        logic        hist[36];
        logic        d;

        fill_pat = 8'b1011_0010;
        drop_pat = 8'hC3;
        lb_pat   = 20'b1101_0011_1000_1011_0110;

        rst_n_a = 1'b0; di_a = 1'b0; stb_a = 1'b0; dout_a = '0;
        rst_n_b = 1'b0; di_b = 1'b0; stb_b = 1'b0; dout_b = '0;

        fork
            begin
                #100000;
                $display("[TB] FAIL watchdog: simulation time limit reached");
                $fatal(1, "[TB] watchdog");
            end
            // Scoreboard monitor: every cycle with out_valid high must consume one expected bit.
            forever begin
                @(negedge clk);
                if (rst_n_a && out_valid_a) begin
                    if (exp_a.size() == 0) checkOutput("a_extra_out_valid", 32'(out_valid_a), 32'd0);
                    else checkOutput("a_sdo", 32'(sdo_a), 32'(exp_a.pop_front()));
                end
                if (rst_n_b && out_valid_b) begin
                    if (exp_b.size() == 0) checkOutput("b_extra_out_valid", 32'(out_valid_b), 32'd0);
                    else checkOutput("b_sdo", 32'(sdo_b), 32'(exp_b.pop_front()));
                end
            end
        join_none

        repeat (2) @(negedge clk);
        checkAllZero("a_rst", din_a, sdo_a, busy_a, in_full_a, out_valid_a, stb_drop_a);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        $display("[TB] fill and same-cycle capture");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, fill_pat[7-i], 1'b0);
            checkOutput("a_fill_in_full", 32'(in_full_a), 32'(i == 7));
        end
        dout_a = 8'hA5;
        pushByte(0, 8'hA5);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("a_din_loaded", 32'(din_a), 32'hB2);
        checkOutput("a_in_full_restart", 32'(in_full_a), 32'd0);
        checkOutput("a_busy_cap0", 32'(busy_a), 32'd0);
        drainCheck(0, 0);

        $display("[TB] delayed capture");
        pushByte(1, 8'hFF);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("b_busy_s0", 32'(busy_b), 32'd1);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("b_busy_s1", 32'(busy_b), 32'd1);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("b_busy_s2", 32'(busy_b), 32'd1);
        dout_b = 8'hFF;
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("b_busy_s3", 32'(busy_b), 32'd0);
        dout_b = 8'h0F;
        drainCheck(1, 0);

        $display("[TB] dropped strobe");
        for (int i = 0; i < 8; i++) applyStimulus(1, drop_pat[7-i], 1'b0);
        dout_b = 8'h3C;
        pushByte(1, 8'h3C);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("b_drop_din_first", 32'(din_b), 32'hC3);
        checkOutput("b_drop_pulse_early", 32'(stb_drop_b), 32'd0);
        applyStimulus(1, 1'b1, 1'b1);
        checkOutput("b_drop_pulse", 32'(stb_drop_b), 32'd1);
        checkOutput("b_drop_din_kept", 32'(din_b), 32'hC3);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("b_drop_pulse_end", 32'(stb_drop_b), 32'd0);
        checkOutput("b_drop_busy", 32'(busy_b), 32'd1);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("b_drop_idle", 32'(busy_b), 32'd0);
        drainCheck(1, 0);

        $display("[TB] strobe on capture edge");
        pushByte(1, 8'h3C);
        applyStimulus(1, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("b_capedge_busy", 32'(busy_b), 32'd0);
        checkOutput("b_capedge_drop", 32'(stb_drop_b), 32'd1);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("b_capedge_drop_end", 32'(stb_drop_b), 32'd0);
        checkOutput("b_capedge_no_accept", 32'(busy_b), 32'd0);
        drainCheck(1, 1);

        $display("[TB] reset during wait");
        for (int i = 0; i < 8; i++) applyStimulus(1, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b1);
        checkOutput("b_rstwait_busy", 32'(busy_b), 32'd1);
        checkOutput("b_rstwait_din", 32'(din_b), 32'hFF);
        #2;
        rst_n_b = 1'b0;
        stb_b   = 1'b0;
        di_b    = 1'b0;
        #1;
        checkAllZero("b_rstwait", din_b, sdo_b, busy_b, in_full_b, out_valid_b, stb_drop_b);
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1'b0, 1'b0);
            checkOutput("b_postrst_busy", 32'(busy_b), 32'd0);
            checkOutput("b_postrst_out_valid", 32'(out_valid_b), 32'd0);
        end

        $display("[TB] loopback");
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        for (int i = 0; i < 36; i++) begin
            d = (i < 20) ? lb_pat[19-i] : 1'b0;
            hist[i] = d;
            applyStimulus(0, d, 1'b0);
            checkOutput("a_loop_sdo", 32'(sdo_a), (i >= 15) ? 32'(hist[i-15]) : 32'd0);
            checkOutput("a_loop_in_full", 32'(in_full_a), 32'(i >= 7));
        end
        checkOutput("a_loop_out_valid", 32'(out_valid_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
